// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch / wait-for-response / execute loop that drives the
// instruction fetch port and computes the next PC. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic [31:0] csr_pc,
    input  logic [31:0] trap_vec,
    output logic        misalign,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        EXEC
    } state_t;

    state_t      state;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        trap;

    assign ifu_addr = pc;

    // Jump-and-link-register style targets always have bit 0 cleared.
    always_comb begin
        target = pc + 32'd4;
        case (pc_src)
            2'b01:   target = pc + imm;
            2'b10:   target = (rs1 + imm) & ~32'd1;
            2'b11:   target = csr_pc;
            default: target = pc + 32'd4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign trap    = (target[1:0] != 2'b00);
    assign next_pc = trap ? trap_vec : target;
`else
    logic unused_trap_vec;
    assign unused_trap_vec = ^trap_vec;
    assign trap    = 1'b0;
    assign next_pc = target;
`endif

    // The request stays low during the first cycle out of reset, so a ready seen there
    // cannot complete a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            inst          <= 32'h0000_0013;
            inst_valid    <= 1'b0;
            misalign      <= 1'b0;
            ifu_req_valid <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                FETCH: begin
                    if (ifu_req_valid && ifu_req_ready) begin
                        ifu_req_valid <= 1'b0;
                        state         <= WAIT;
                    end else begin
                        ifu_req_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ifu_rsp_valid) begin
                        inst       <= ifu_rsp_data;
                        inst_valid <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        pc            <= next_pc;
                        misalign      <= trap;
                        inst_valid    <= 1'b0;
                        ifu_req_valid <= 1'b1;
                        state         <= FETCH;
                    end
                end
                default: begin
                    state         <= FETCH;
                    ifu_req_valid <= 1'b0;
                    inst_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, giving the PC value loaded at reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port ifu_req_valid, output, 1, the fetch request valid.
REQ-005 The block SHALL have port ifu_req_ready, input, 1, the memory accepts the request.
REQ-006 The block SHALL have port ifu_addr, output, 32, the fetch address; it equals pc.
REQ-007 The block SHALL have port ifu_rsp_valid, input, 1, the fetch data is valid.
REQ-008 The block SHALL have port ifu_rsp_data, input, 32, the fetched instruction.
REQ-009 The block SHALL have port inst, output, 32, the latched instruction for decode.
REQ-010 The block SHALL have port inst_valid, output, 1, inst is valid and execution is in progress.
REQ-011 The block SHALL have port exec_done, input, 1, the execute stage has produced pc_src and operands.
REQ-012 The block SHALL have port pc_src, input, 2, the next-PC select: 00 pc+4; 01 pc+imm; 10 rs1+imm; 11 csr_pc.
REQ-013 The block SHALL have ports imm, rs1 and csr_pc, each input, 32, the operands for next-PC computation.
REQ-014 The block SHALL have port trap_vec, input, 32, the misalignment trap target.
REQ-015 The block SHALL have port misalign, output, 1, a one-cycle pulse on a misaligned-target trap.
REQ-016 The block SHALL have port pc, output, 32, the current PC register.

Function
REQ-017 The block SHALL implement a three-state FSM: FETCH, WAIT, EXEC.
REQ-018 In FETCH, ifu_req_valid SHALL be 1 and ifu_addr SHALL equal pc, held stable until ifu_req_ready=1, which moves the FSM to WAIT.
REQ-019 In WAIT, ifu_req_valid SHALL be 0; ifu_rsp_valid=1 SHALL latch ifu_rsp_data into inst and move the FSM to EXEC.
REQ-020 ifu_rsp_valid SHALL be ignored outside WAIT, including a response in the same cycle as request acceptance.
REQ-021 In EXEC, inst_valid SHALL be 1; exec_done=1 SHALL update pc with the next PC and move the FSM to FETCH.
REQ-022 exec_done SHALL be ignored outside EXEC.
REQ-023 The next PC SHALL be computed modulo 2^32, with carry discarded, as follows: 00 -> pc+4; 01 -> pc+imm; 10 -> (rs1+imm) with bit0 cleared; 11 -> csr_pc unmodified.
REQ-024 The minimum time per instruction SHALL be 3 cycles, with ready and the response each arriving on the first cycle they are sampled.
REQ-025 inst SHALL hold its value from EXEC until the next latch; inst_valid SHALL be 0 in FETCH and WAIT.
REQ-026 The block SHALL have no timeout; it SHALL wait indefinitely in FETCH or WAIT.

Reset
REQ-027 While rst=1, the block SHALL set state=FETCH, pc=RESET_PC, inst=32'h0000_0013, inst_valid=0, misalign=0 and ifu_req_valid=0.
REQ-028 On the first clock edge after rst falls, ifu_req_valid SHALL be 1 with ifu_addr=RESET_PC.
REQ-029 Reset in any state, mid-handshake included, SHALL abort the operation immediately; a late response SHALL be ignored because the FSM is in FETCH.

Configuration
REQ-030 When PC_MISALIGN_TRAP_EN is defined and exec_done selects a next PC whose bits[1:0] are non-zero, pc SHALL be loaded with trap_vec and misalign SHALL pulse 1 for one cycle, on the cycle after the update.
REQ-031 When PC_MISALIGN_TRAP_EN is undefined, misalign SHALL be tied to 0, trap_vec SHALL be ignored, and the next PC SHALL be loaded unchanged.

Verification
REQ-032 Bench SHALL cover: reset released, ready and response immediate, pc_src=00 -> ifu_addr sequence 8000_0000, 8000_0004, 8000_0008, 3 cycles apart.
REQ-033 Bench SHALL cover: ready held 0 for 4 cycles -> ifu_req_valid stays 1 with ifu_addr stable for 4 cycles, and no state advance.
REQ-034 Bench SHALL cover: pc=8000_0010, pc_src=10, rs1=8000_0101, imm=2 -> next pc=8000_0102 (bit0 cleared).
REQ-035 Bench SHALL cover: pc=FFFF_FFFC, pc_src=00 -> pc wraps to 0000_0000; pc_src=01 with imm=FFFF_FFF8 from pc=8000_0010 -> 8000_0008.
REQ-036 Bench SHALL cover: with the macro defined, pc_src=01 and target 8000_0006, trap_vec=8000_0100 -> pc=8000_0100 and misalign pulses for one cycle; with the macro undefined -> pc=8000_0006 and misalign=0.
REQ-037 Bench SHALL cover: rst asserted in WAIT, then the response arrives one cycle after rst falls -> response ignored, inst=0000_0013, refetch from RESET_PC.
